// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared op codes, state encoding and width enum for the data-memory sequencer
package dmem_pkg;

    localparam logic [5:0] OP_LB  = 6'b001011;
    localparam logic [5:0] OP_LH  = 6'b001100;
    localparam logic [5:0] OP_LW  = 6'b001101;
    localparam logic [5:0] OP_LBU = 6'b001110;
    localparam logic [5:0] OP_LHU = 6'b001111;
    localparam logic [5:0] OP_SB  = 6'b010000;
    localparam logic [5:0] OP_SH  = 6'b010001;
    localparam logic [5:0] OP_SW  = 6'b010010;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD
    } width_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - width decode, alignment check, byte enables, lane replication and read shift
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [5:0]  op,
    input  logic        read_en,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [1:0]  rd_off,
    input  logic [31:0] rdata,
    output logic        fault,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata_shifted
);

    width_t width;
    logic   op_load;
    logic   op_store;
    logic   misaligned;
    logic [4:0] shamt;

    always_comb begin
        width    = BYTE;
        op_load  = 1'b0;
        op_store = 1'b0;
        case (op)
            OP_LB, OP_LBU: begin width = BYTE; op_load  = 1'b1; end
            OP_LH, OP_LHU: begin width = HALF; op_load  = 1'b1; end
            OP_LW:         begin width = WORD; op_load  = 1'b1; end
            OP_SB:         begin width = BYTE; op_store = 1'b1; end
            OP_SH:         begin width = HALF; op_store = 1'b1; end
            OP_SW:         begin width = WORD; op_store = 1'b1; end
            default:       begin width = BYTE; end
        endcase
    end

    // A read enable wins over a write enable, so the op kind must match the read flag.
    always_comb begin
        misaligned = ((width == HALF) && addr_lo[0]) ||
                     ((width == WORD) && (addr_lo != 2'b00));
        fault      = (read_en ? !op_load : !op_store) || misaligned;
    end

    always_comb begin
        be    = 4'b1111;
        wdata = 32'h0;
        if (!read_en) begin
            case (width)
                BYTE: begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                HALF: begin
                    be    = 4'b0011 << addr_lo;
                    wdata = {2{store_data[15:0]}};
                end
                default: begin
                    be    = 4'b1111;
                    wdata = store_data;
                end
            endcase
        end
    end

    assign shamt         = {rd_off, 3'b000};
    assign rdata_shifted = rdata >> shamt;

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM/WB data-memory access sequencer with pipeline stall and fault pulses
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_en,
    input  logic              mem_write_en,
    input  logic [5:0]        aluSelect,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              misalign_fault,
    output logic              bus_fault,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  tcnt;
    logic        rd_q;
    logic [1:0]  off_q;
    logic        stall_q;

    logic        req_any;
    logic        accept;
    logic        lane_fault;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] rdata_shifted;

    dmem_lane_align u_lane (
        .op            (aluSelect),
        .read_en       (mem_read_en),
        .addr_lo       (addr[1:0]),
        .store_data    (store_data),
        .rd_off        (off_q),
        .rdata         (dmem_rdata),
        .fault         (lane_fault),
        .be            (lane_be),
        .wdata         (lane_wdata),
        .rdata_shifted (rdata_shifted)
    );

    assign req_any = mem_read_en | mem_write_en;
    assign accept  = (state == IDLE) && req_any && !lane_fault;

    // The accepting cycle must freeze the pipeline before the registered stall catches up.
    assign stall = stall_q | accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            tcnt           <= 8'd0;
            rd_q           <= 1'b0;
            off_q          <= 2'b00;
            stall_q        <= 1'b0;
            load_data      <= 32'h0;
            load_valid     <= 1'b0;
            misalign_fault <= 1'b0;
            bus_fault      <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_be        <= 4'b0000;
            dmem_wdata     <= 32'h0;
        end else begin
            load_valid     <= 1'b0;
            misalign_fault <= 1'b0;
            bus_fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        if (lane_fault) begin
                            misalign_fault <= 1'b1;
                        end else begin
                            state      <= REQ;
                            tcnt       <= 8'd0;
                            stall_q    <= 1'b1;
                            dmem_req   <= 1'b1;
                            dmem_we    <= !mem_read_en;
                            dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            dmem_be    <= lane_be;
                            dmem_wdata <= lane_wdata;
                            rd_q       <= mem_read_en;
                            off_q      <= addr[1:0];
                        end
                    end
                end
                REQ: begin
                    // Ack is checked first so an ack on the last allowed cycle still succeeds.
                    if (dmem_ack) begin
                        state      <= DONE;
                        dmem_req   <= 1'b0;
                        stall_q    <= 1'b0;
                        load_valid <= rd_q;
                        if (rd_q) begin
                            load_data <= rdata_shifted;
                        end
                    end else if (tcnt == TO_LAST) begin
                        state     <= IDLE;
                        dmem_req  <= 1'b0;
                        stall_q   <= 1'b0;
                        bus_fault <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - vector table, random model comparison and corner sequences for dmem_access_ctrl
module tb_dmem_access_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [5:0]  aluSelect;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign_fault;
    logic        bus_fault;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .aluSelect      (aluSelect),
        .addr           (addr),
        .store_data     (store_data),
        .stall          (stall),
        .load_data      (load_data),
        .load_valid     (load_valid),
        .misalign_fault (misalign_fault),
        .bus_fault      (bus_fault),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: access size in bytes, kind match, byte-lane arithmetic.
    function automatic void model(input logic [5:0] op, input logic rd, input logic [31:0] a,
                                  input logic [31:0] sd, input logic [31:0] rdat,
                                  output logic f, output logic [3:0] be,
                                  output logic [31:0] wd, output logic [31:0] ld);
        int size;
        bit is_ld;
        bit is_st;
        int off;
        size  = 0;
        is_ld = 0;
        is_st = 0;
        case (op)
            6'b001011, 6'b001110: begin size = 1; is_ld = 1; end
            6'b001100, 6'b001111: begin size = 2; is_ld = 1; end
            6'b001101:            begin size = 4; is_ld = 1; end
            6'b010000:            begin size = 1; is_st = 1; end
            6'b010001:            begin size = 2; is_st = 1; end
            6'b010010:            begin size = 4; is_st = 1; end
            default:              size = 0;
        endcase
        off = int'(a % 4);
        if (size == 0) f = 1'b1;
        else f = !(rd ? is_ld : is_st) || ((off % size) != 0);
        be = 4'hF;
        wd = 32'h0;
        if (!rd && size != 0) begin
            be = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % size) +: 8];
        end
        ld = rdat >> (8 * off);
    endfunction

    // ack_dly: REQ cycle (1-based) in which ack is given; 0 means never.
    task automatic do_access(input logic [5:0] op, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                             input int ack_dly, input logic e_fault, input logic [3:0] e_be,
                             input logic [31:0] e_wdata, input logic [31:0] e_load);
        int stall_n;
        logic acked;
        logic is_rd;
        is_rd = rd;
        @(negedge clk);
        aluSelect    = op;
        mem_read_en  = rd;
        mem_write_en = wr;
        addr         = a;
        store_data   = sd;
        #1;
        chk1("stall_request_cycle", stall, !e_fault);
        stall_n = stall ? 1 : 0;
        @(negedge clk);
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        addr         = $urandom;
        store_data   = $urandom;
        if (e_fault) begin
            chk1("misalign_pulse", misalign_fault, 1'b1);
            chk1("no_req_on_fault", dmem_req, 1'b0);
            chk1("stall_on_fault", stall, 1'b0);
            @(negedge clk);
            chk1("misalign_clear", misalign_fault, 1'b0);
            return;
        end
        chk1("no_misalign", misalign_fault, 1'b0);
        acked = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            chk1("dmem_req_held", dmem_req, 1'b1);
            chk1("stall_in_req", stall, 1'b1);
            if (stall) stall_n++;
            chk32("dmem_addr", dmem_addr, {a[31:2], 2'b00});
            chk1("dmem_we", dmem_we, !is_rd);
            chk32("dmem_be", {28'h0, dmem_be}, {28'h0, e_be});
            if (!is_rd) chk32("dmem_wdata", dmem_wdata, e_wdata);
            if (k == ack_dly) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdat;
            end
            @(negedge clk);
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            if (k == ack_dly) begin
                acked = 1'b1;
                break;
            end
        end
        if (acked) begin
            chk1("load_valid_done", load_valid, is_rd);
            chk1("stall_done", stall, 1'b0);
            chk1("req_drop_done", dmem_req, 1'b0);
            chk1("no_bus_fault", bus_fault, 1'b0);
            if (is_rd) chk32("load_data", load_data, e_load);
            chk32("stall_cycles", stall_n, ack_dly + 1);
        end else begin
            chk1("bus_fault_pulse", bus_fault, 1'b1);
            chk1("req_drop_timeout", dmem_req, 1'b0);
            chk1("stall_timeout", stall, 1'b0);
            chk1("no_load_valid_timeout", load_valid, 1'b0);
            chk32("stall_cycles_timeout", stall_n, TO + 1);
        end
        @(negedge clk);
        chk1("load_valid_clear", load_valid, 1'b0);
        chk1("bus_fault_clear", bus_fault, 1'b0);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rdat;
        int          ack_dly;
        logic        e_fault;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_load;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [5:0] codes[9];
        logic f;
        logic [3:0] be;
        logic [31:0] wd;
        logic [31:0] ld;

        vecs[0]  = '{6'b001101, 1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0, 4'hF, 32'h0, 32'hDEADBEEF};
        vecs[1]  = '{6'b001110, 1, 0, 32'h203, 32'h0, 32'hA5112233, 1, 0, 4'hF, 32'h0, 32'h000000A5};
        vecs[2]  = '{6'b010001, 0, 1, 32'h302, 32'h0000BEEF, 32'h0, 1, 0, 4'hC, 32'hBEEFBEEF, 32'h0};
        vecs[3]  = '{6'b001100, 1, 0, 32'h401, 32'h0, 32'h0, 1, 1, 4'hF, 32'h0, 32'h0};
        vecs[4]  = '{6'b010010, 0, 1, 32'h404, 32'h12345678, 32'h0, 2, 0, 4'hF, 32'h12345678, 32'h0};
        vecs[5]  = '{6'b001011, 1, 0, 32'h601, 32'h0, 32'h11223344, 1, 0, 4'hF, 32'h0, 32'h00112233};
        vecs[6]  = '{6'b010000, 0, 1, 32'h503, 32'h000000AB, 32'h0, 1, 0, 4'h8, 32'hABABABAB, 32'h0};
        vecs[7]  = '{6'b001111, 1, 0, 32'h702, 32'h0, 32'hCAFEBABE, 1, 0, 4'hF, 32'h0, 32'h0000CAFE};
        vecs[8]  = '{6'b001101, 1, 1, 32'h800, 32'hFFFFFFFF, 32'h55AA55AA, 2, 0, 4'hF, 32'h0, 32'h55AA55AA};
        vecs[9]  = '{6'b010010, 1, 0, 32'h900, 32'h0, 32'h0, 1, 1, 4'hF, 32'h0, 32'h0};
        vecs[10] = '{6'b001101, 0, 1, 32'h904, 32'h0, 32'h0, 1, 1, 4'hF, 32'h0, 32'h0};
        vecs[11] = '{6'b111111, 1, 0, 32'h908, 32'h0, 32'h0, 1, 1, 4'hF, 32'h0, 32'h0};
        vecs[12] = '{6'b010010, 0, 1, 32'hA02, 32'h0, 32'h0, 1, 1, 4'hF, 32'h0, 32'h0};
        vecs[13] = '{6'b001101, 1, 0, 32'hB00, 32'h0, 32'h0BADF00D, TO, 0, 4'hF, 32'h0, 32'h0BADF00D};

        codes = '{6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b001111,
                  6'b010000, 6'b010001, 6'b010010, 6'b000000};

        rst_n        = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        aluSelect    = 6'h0;
        addr         = 32'h0;
        store_data   = 32'h0;
        dmem_rdata   = 32'h0;
        dmem_ack     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_req", dmem_req, 1'b0);
        chk1("rst_we", dmem_we, 1'b0);
        chk32("rst_load_data", load_data, 32'h0);
        chk32("rst_addr", dmem_addr, 32'h0);
        chk32("rst_be_wdata", {28'h0, dmem_be} | dmem_wdata, 32'h0);
        chk1("rst_pulses", load_valid | misalign_fault | bus_fault, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            do_access(vecs[i].op, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].sd, vecs[i].rdat,
                      vecs[i].ack_dly, vecs[i].e_fault, vecs[i].e_be, vecs[i].e_wdata, vecs[i].e_load);

        // Timeout with no ack, then a normal load completes.
        do_access(6'b001101, 1, 0, 32'hC00, 32'h0, 32'h0, 0, 0, 4'hF, 32'h0, 32'h0);
        do_access(6'b001101, 1, 0, 32'hC04, 32'h0, 32'h13579BDF, 1, 0, 4'hF, 32'h0, 32'h13579BDF);

        // Reset while a request is outstanding.
        @(negedge clk);
        aluSelect   = 6'b001101;
        mem_read_en = 1'b1;
        addr        = 32'hD00;
        @(negedge clk);
        mem_read_en = 1'b0;
        @(negedge clk);
        chk1("req_before_reset", dmem_req, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk1("reset_req_drop", dmem_req, 1'b0);
        chk1("reset_stall_drop", stall, 1'b0);
        chk1("reset_pulses", load_valid | misalign_fault | bus_fault, 1'b0);
        chk32("reset_addr", dmem_addr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("post_reset_idle", dmem_req | bus_fault | load_valid, 1'b0);
        do_access(6'b010000, 0, 1, 32'h501, 32'h0000005A, 32'h0, 1, 0, 4'h2, 32'h5A5A5A5A, 32'h0);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            logic rd;
            logic wr;
            logic [31:0] a;
            logic [31:0] sd;
            logic [31:0] rdat;
            int sel;
            int dly;
            op   = codes[$urandom_range(0, 8)];
            sel  = $urandom_range(0, 2);
            rd   = (sel != 1);
            wr   = (sel != 0);
            a    = $urandom;
            sd   = $urandom;
            rdat = $urandom;
            dly  = $urandom_range(1, 4);
            model(op, rd, a, sd, rdat, f, be, wd, ld);
            do_access(op, rd, wr, a, sd, rdat, dly, f, be, wd, ld);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Multi-cycle data-memory access sequencer in the MEM/WB boundary of the RV32I pipeline.
- Accepts one load/store per instruction from the MEM stage and stalls the pipeline while the variable-latency data memory responds.
- For loads, right-aligns the addressed byte/halfword/word so the writeback load converter only masks or sign-extends.
- For stores, generates byte enables and lane-replicated write data. Detects misalignment and bus timeout.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in REQ without dmem_ack before the bus fault; legal range 2..255.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- mem_read_en  in  1  MEM stage requests a load this cycle
- mem_write_en  in  1  MEM stage requests a store this cycle
- aluSelect  in  6  op code: LB 001011, LH 001100, LW 001101, LBU 001110, LHU 001111, SB 010000, SH 010001, SW 010010
- addr  in  ADDR_W  byte address from ALU
- store_data  in  32  rs2 value, right-aligned
- stall  out  1  hold PC and IF/ID, ID/EX, EX/MEM registers
- load_data  out  32  right-aligned raw load data to the writeback load converter
- load_valid  out  1  one-cycle pulse, load_data valid
- misalign_fault  out  1  one-cycle pulse, misaligned access rejected
- bus_fault  out  1  one-cycle pulse, access timed out
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  write data, replicated to lanes
- dmem_rdata  in  32  read word
- dmem_ack  in  1  access complete; rdata valid this cycle

Behaviour:
- Reset (rst_n=0 at posedge, any state): state=IDLE, timeout counter=0. All outputs are 0: load_data, load_valid, misalign_fault, bus_fault, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall. An in-flight request is abandoned with no pulse.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - mem_read_en and mem_write_en both 1 is illegal. Treat it as a read and ignore the write.
  - Alignment rule: halfword ops need addr[0]=0; word ops need addr[1:0]=00.
  - Misaligned request: misalign_fault=1 next cycle, no dmem_req, stall=0, stay IDLE.
  - Aligned request: stall=1 combinationally the same cycle. Register op, addr, and lane data. Next state is REQ.
  - A read enable with a store code, or a write enable with a load code, counts as misaligned (fault).
- REQ:
  - dmem_req=1 and stall=1. dmem_addr, dmem_we, dmem_be, and dmem_wdata stay stable until ack.
  - Timeout counter increments every REQ cycle without ack.
  - On dmem_ack: reads latch the shifted dmem_rdata into load_data, then go to DONE.
  - Counter reaching TIMEOUT_CYCLES-1 without ack: dmem_req drops, bus_fault=1 next cycle, return to IDLE.
  - Ack on the timeout cycle counts as success (ack wins).
- DONE:
  - Exactly 1 cycle. stall=0, and load_valid=1 for loads only. Return to IDLE.
  - A new request seen in DONE is ignored. The pipeline presents it again in the next (IDLE) cycle.
- Latency with ack in the first REQ cycle: request cycle T, dmem_req at T+1, load_valid at T+2. The minimum stall is 2 cycles.
- Load alignment:
  - load_data = dmem_rdata >> (8*addr[1:0]).
  - Bits above the access width are forwarded unmasked. Masking and sign extension belong to the load converter.
- Store lanes:
  - SB: be = 0001 << addr[1:0], wdata = {4{sd[7:0]}}.
  - SH: be = 0011 << addr[1:0], wdata = {2{sd[15:0]}}.
  - SW: be = 1111, wdata = sd.
  - Loads drive be = 1111.
- Unknown aluSelect code with an enable: misalign_fault.

Decomposition:
- Shared package dmem_pkg holds:
  - aluSelect load/store code constants;
  - state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2);
  - access-width enum (BYTE, HALF, WORD);
  - default TIMEOUT_CYCLES.
- One sub-module: dmem_lane_align. It is combinational and computes width decode, alignment check, be, replicated wdata, and the read shift. It is reused by the future store buffer.

Test Plan:
- LW, addr=0x100, rdata=0xDEADBEEF, ack 3 cycles after req → stall high for 4 cycles, load_valid once, load_data=0xDEADBEEF, dmem_addr=0x100.
- LBU, addr=0x203, rdata=0xA5112233, ack immediate → load_data=0x000000A5, dmem_be=1111, minimum stall 2 cycles.
- SH, addr=0x302, store_data=0x0000BEEF → dmem_we=1, be=1100, wdata=0xBEEFBEEF, no load_valid.
- LH, addr=0x401 → misalign_fault pulse next cycle, dmem_req never asserted, stall 0.
- LW with ack never asserted → dmem_req high for TIMEOUT_CYCLES cycles, then bus_fault pulse, return to IDLE; a following LW with ack completes normally.
- rst_n=0 during REQ → next cycle dmem_req=0, stall=0, all pulses 0; after release, a new SB at 0x501 gives be=0010.
